// File: rtl/divisor_secuencial_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divisor_pkg;
  localparam int N_BITS_DEF = 8;
  localparam int W_DIV_DEF  = 4;

  typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divisor_secuencial_if.sv
// Request/response bundle between a divider client and divisor_secuencial.
interface divisor_secuencial_if
  import divisor_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int W_DIV  = W_DIV_DEF
);
  logic              start;
  logic [N_BITS-1:0] dividendo;
  logic [W_DIV-1:0]  divisor;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] cociente;
  logic [W_DIV-1:0]  residuo;
  logic              div_cero;

  modport master (output start, dividendo, divisor,
                  input  busy, done, cociente, residuo, div_cero);
  modport slave  (input  start, dividendo, divisor,
                  output busy, done, cociente, residuo, div_cero);
endinterface

// File: rtl/divisor_secuencial_paso.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_paso #(
  parameter int W_DIV = 4
) (
  input  logic [W_DIV-1:0] rem_prev,
  input  logic             bit_in,
  input  logic [W_DIV-1:0] divisor,
  output logic             q_bit,
  output logic [W_DIV-1:0] rem_next
);
  logic [W_DIV:0] shifted;
  logic [W_DIV:0] diff;

  assign shifted = {rem_prev, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // rem_prev < divisor always, so shifted < 2*divisor and the top bit of
  // the (W_DIV+1)-bit difference is exactly the borrow.
  assign q_bit    = ~diff[W_DIV];
  assign rem_next = q_bit ? diff[W_DIV-1:0] : shifted[W_DIV-1:0];
endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: one quotient bit per CALC cycle, MSB first.
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int W_DIV  = W_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  divisor_secuencial_if.slave  bus
);
  localparam int CW = cnt_w(N_BITS);

  estado_t           state, next;
  logic [CW-1:0]     cnt;
  logic [N_BITS-1:0] dvd;
  logic [W_DIV-1:0]  dsr;
  logic [N_BITS-1:0] coc;
  logic [W_DIV-1:0]  res;
  logic              dz;
  logic              q_bit;
  logic [W_DIV-1:0]  rem_next;

  div_paso #(.W_DIV(W_DIV)) u_paso (
    .rem_prev (res),
    .bit_in   (dvd[N_BITS-1]),
    .divisor  (dsr),
    .q_bit    (q_bit),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (bus.start) next = (bus.divisor == '0) ? FIN : CALC;
      CALC:    if (cnt == '0) next = FIN;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // cociente/residuo double as the working quotient and partial remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      coc <= '0;
      res <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.divisor != '0) begin
            dvd <= bus.dividendo;
            dsr <= bus.divisor;
            coc <= '0;
            res <= '0;
            cnt <= CW'(N_BITS - 1);
            dz  <= 1'b0;
          end else begin
            coc <= '1;
            res <= '0;
            dz  <= 1'b1;
          end
        end
        CALC: begin
          coc <= {coc[N_BITS-2:0], q_bit};
          res <= rem_next;
          dvd <= {dvd[N_BITS-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.cociente = coc;
  assign bus.residuo  = res;
  assign bus.div_cero = dz;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Table-driven and exhaustive checks of divisor_secuencial with a result scoreboard.
module tb_divisor_secuencial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divisor_secuencial_if #(.N_BITS(8), .W_DIV(4)) bus ();
  divisor_secuencial #(.N_BITS(8), .W_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [7:0] q; logic [3:0] r; logic dz; } exp_t;
  typedef struct { logic [7:0] a; logic [3:0] b; logic [7:0] q; logic [3:0] r; logic dz; } vec_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request, then wait (bounded) for done and compare against the scoreboard.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r, input logic dz,
                       input bit full);
    exp_t e;
    int   cyc;
    int   lat;
    e.q = q; e.r = r; e.dz = dz;
    sb.push_back(e);
    lat = dz ? 1 : 9;
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividendo = 8'($urandom);
    bus.divisor   = 4'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    if (!bus.done) begin
      errs++; checks++;
      $display("FAIL timeout a=%0d b=%0d: no done after %0d cycles", a, b, cyc);
      return;
    end
    if (full) begin
      chk("latency", cyc, lat);
      chk("busy_at_done", bus.busy, 1'b1);
    end
    chk($sformatf("q %0d/%0d", a, b), bus.cociente, e.q);
    chk($sformatf("r %0d/%0d", a, b), bus.residuo, e.r);
    chk($sformatf("dz %0d/%0d", a, b), bus.div_cero, e.dz);
    if (full) begin
      @(negedge clk);
      chk("done_one_cycle", bus.done, 1'b0);
      chk("busy_after", bus.busy, 1'b0);
      chk("q_hold", bus.cociente, e.q);
      chk("r_hold", bus.residuo, e.r);
      chk("dz_hold", bus.div_cero, e.dz);
    end
  endtask

  vec_t tbl[10];

  initial begin
    int pulses;
    int high;
    bit prev;

    tbl[0] = '{8'd100, 4'd7,  8'd14,  4'd2,  1'b0};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    tbl[2] = '{8'd250, 4'd12, 8'd20,  4'd10, 1'b0};
    tbl[3] = '{8'd13,  4'd0,  8'hFF,  4'd0,  1'b1};
    tbl[4] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
    tbl[5] = '{8'd200, 4'd3,  8'd66,  4'd2,  1'b0};
    tbl[6] = '{8'd0,   4'd1,  8'd0,   4'd0,  1'b0};
    tbl[7] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    tbl[8] = '{8'd1,   4'd15, 8'd0,   4'd1,  1'b0};
    tbl[9] = '{8'd128, 4'd2,  8'd64,  4'd0,  1'b0};

    bus.start = 1'b0; bus.dividendo = '0; bus.divisor = '0;
    rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_q", bus.cociente, 8'h00);
    chk("rst_r", bus.residuo, 4'h0);
    chk("rst_dz", bus.div_cero, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 1'b1);

    // start held high across busy: one acceptance per IDLE visit
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = 8'd5; bus.divisor = 4'd9;
    pulses = 0; high = 0; prev = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 19) bus.start = 1'b0;
      if (bus.done) begin
        high++;
        if (!prev) pulses++;
        chk("held_q", bus.cociente, 8'd0);
        chk("held_r", bus.residuo, 4'd5);
      end
      prev = bus.done;
    end
    chk("held_pulses", pulses, 2);
    chk("held_high_cycles", high, 2);

    // reset in the middle of CALC aborts the operation
    do_op(8'd13, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = 8'd100; bus.divisor = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_q", bus.cociente, 8'h00);
    chk("abort_r", bus.residuo, 4'h0);
    chk("abort_dz", bus.div_cero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    high = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) high++;
    end
    chk("abort_no_done", high, 0);
    do_op(8'd200, 4'd3, 8'd66, 4'd2, 1'b0, 1'b1);

    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        do_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
